// File: rtl/persiana_pkg.sv
// Shared definitions for the blind motor driver: FSM state encoding and default sizing.
package persiana_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD   = 3'd1,
        RUN_UP = 3'd2,
        RUN_DN = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int PWM_BITS_DEF         = 8;
    localparam int DEAD_CYCLES_DEF      = 16;
    localparam int RAMP_STEP_CYCLES_DEF = 256;
    localparam int TIMEOUT_CYCLES_DEF   = 2**20;

    function automatic logic is_run(input state_t s);
        return (s == RUN_UP) || (s == RUN_DN);
    endfunction

endpackage

// File: rtl/persiana_pwm_gen.sv
// Free-running PWM counter; pwm_on is high while the counter is below the duty value.
module persiana_pwm_gen
    import persiana_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] pwm_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt_reg < duty);

endmodule

// File: rtl/persiana_motor_driver.sv
// H-bridge driver for the blind motor: dead time, PWM, end-stop cut-off and travel timeout.
// Define PERSIANA_SOFT_START_EN to ramp duty from 0; otherwise runs start at full duty.
module persiana_motor_driver
    import persiana_pkg::*;
#(
    parameter int PWM_BITS         = PWM_BITS_DEF,
    parameter int DEAD_CYCLES      = DEAD_CYCLES_DEF,
    parameter int RAMP_STEP_CYCLES = RAMP_STEP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES   = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                subir,
    input  logic                bajar,
    input  logic                Ssup,
    input  logic                Sinf,
    output logic                motor_a,
    output logic                motor_b,
    output logic                moving,
    output logic                fault,
    output logic [PWM_BITS-1:0] duty
);

    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int RUN_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    if (DEAD_CYCLES < 1 || RAMP_STEP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("persiana_motor_driver: DEAD_CYCLES, RAMP_STEP_CYCLES must be >= 1, TIMEOUT_CYCLES >= 2");
    end

    state_t              state_reg;
    logic [DEAD_W-1:0]   dead_cnt_reg;
    logic [RUN_W-1:0]    run_cnt_reg;
    logic [PWM_BITS-1:0] duty_reg;
    logic                motor_a_reg;
    logic                motor_b_reg;
    logic                moving_reg;
    logic                fault_reg;
    logic                pwm_on;
    logic                cmd_up;
    logic                cmd_dn;

`ifdef PERSIANA_SOFT_START_EN
    localparam int RAMP_W = $clog2(RAMP_STEP_CYCLES + 1);
    logic [RAMP_W-1:0]   ramp_cnt_reg;
`endif

    // Both requests high cancel each other; an engaged end-stop blocks travel in its direction.
    assign cmd_up = subir & ~bajar & ~Ssup;
    assign cmd_dn = bajar & ~subir & ~Sinf;

    persiana_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty_reg),
        .pwm_on (pwm_on)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            dead_cnt_reg <= '0;
            run_cnt_reg  <= '0;
            duty_reg     <= '0;
            motor_a_reg  <= 1'b0;
            motor_b_reg  <= 1'b0;
            moving_reg   <= 1'b0;
            fault_reg    <= 1'b0;
`ifdef PERSIANA_SOFT_START_EN
            ramp_cnt_reg <= '0;
`endif
        end else begin
            motor_a_reg <= (state_reg == RUN_UP) && pwm_on;
            motor_b_reg <= (state_reg == RUN_DN) && pwm_on;
            moving_reg  <= is_run(state_reg);
            fault_reg   <= (state_reg == FAULT);

            case (state_reg)
                IDLE: begin
                    if (cmd_up || cmd_dn) begin
                        state_reg    <= DEAD;
                        dead_cnt_reg <= '0;
                    end
                end
                DEAD: begin
                    dead_cnt_reg <= dead_cnt_reg + 1'b1;
                    if (dead_cnt_reg == DEAD_W'(DEAD_CYCLES - 1)) begin
                        run_cnt_reg <= '0;
`ifdef PERSIANA_SOFT_START_EN
                        duty_reg     <= '0;
                        ramp_cnt_reg <= '0;
`else
                        duty_reg     <= DUTY_MAX;
`endif
                        if (cmd_up) begin
                            state_reg <= RUN_UP;
                        end else if (cmd_dn) begin
                            state_reg <= RUN_DN;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                RUN_UP, RUN_DN: begin
                    run_cnt_reg <= run_cnt_reg + 1'b1;
`ifdef PERSIANA_SOFT_START_EN
                    if (ramp_cnt_reg == RAMP_W'(RAMP_STEP_CYCLES - 1)) begin
                        ramp_cnt_reg <= '0;
                        if (duty_reg != DUTY_MAX) begin
                            duty_reg <= duty_reg + 1'b1;
                        end
                    end else begin
                        ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
                    end
`endif
                    // Timeout wins over any simultaneous sensor or command change.
                    if (run_cnt_reg == RUN_W'(TIMEOUT_CYCLES - 1)) begin
                        state_reg <= FAULT;
                    end else if ((state_reg == RUN_UP) ? !cmd_up : !cmd_dn) begin
                        state_reg    <= DEAD;
                        dead_cnt_reg <= '0;
                    end
                end
                FAULT: begin
                    if (!subir && !bajar) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign motor_a = motor_a_reg;
    assign motor_b = motor_b_reg;
    assign moving  = moving_reg;
    assign fault   = fault_reg;
    assign duty    = duty_reg;

endmodule

// File: tb/tb_persiana_motor_driver.sv
// Scoreboard bench for persiana_motor_driver: stimulus queues per-cycle expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_persiana_motor_driver;

    localparam int PWM_BITS         = 4;
    localparam int DEAD_CYCLES      = 4;
    localparam int RAMP_STEP_CYCLES = 2;
    localparam int TIMEOUT_CYCLES   = 100;
    localparam int DMAX             = 15;

    localparam int SEL_A = 0, SEL_B = 1, SEL_MOV = 2, SEL_FLT = 3, SEL_DUTY = 4;

    logic                clk = 1'b0;
    logic                reset, subir, bajar, Ssup, Sinf;
    logic                motor_a, motor_b, moving, fault;
    logic [PWM_BITS-1:0] duty;

    always #5 clk = ~clk;

    persiana_motor_driver #(
        .PWM_BITS         (PWM_BITS),
        .DEAD_CYCLES      (DEAD_CYCLES),
        .RAMP_STEP_CYCLES (RAMP_STEP_CYCLES),
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .subir   (subir),
        .bajar   (bajar),
        .Ssup    (Ssup),
        .Sinf    (Sinf),
        .motor_a (motor_a),
        .motor_b (motor_b),
        .moving  (moving),
        .fault   (fault),
        .duty    (duty)
    );

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   r_last = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected duty k cycles after run entry.
    function automatic int exp_duty(input int k);
`ifdef PERSIANA_SOFT_START_EN
        return (k / RAMP_STEP_CYCLES > DMAX) ? DMAX : k / RAMP_STEP_CYCLES;
`else
        return DMAX;
`endif
    endfunction

    function automatic int pwm_at(input int m);
        return (m - r_last) % (DMAX + 1);
    endfunction

    // Active leg at sample m reflects the pwm compare of the previous cycle.
    function automatic int leg_at(input int m, input int entry);
        return (pwm_at(m - 1) < exp_duty(m - 1 - entry)) ? 1 : 0;
    endfunction

    task automatic expect_at(input int c, input int sel, input int v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Monitor: bridge-safety every cycle plus scoreboard pops.
    initial begin
        exp_t        e;
        logic [31:0] act;
        logic        prev_a = 1'b0;
        logic        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                checks++;
                if (((motor_a & motor_b) | (motor_a & prev_b) | (motor_b & prev_a)) !== 1'b0) begin
                    errors++;
                    $display("FAIL bridge_overlap @cycle %0d: a=%b b=%b prev_a=%b prev_b=%b, want no overlap",
                             cyc, motor_a, motor_b, prev_a, prev_b);
                end
                prev_a = motor_a;
                prev_b = motor_b;
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                case (e.sel)
                    SEL_A:   act = {31'b0, motor_a};
                    SEL_B:   act = {31'b0, motor_b};
                    SEL_MOV: act = {31'b0, moving};
                    SEL_FLT: act = {31'b0, fault};
                    default: act = {{(32-PWM_BITS){1'b0}}, duty};
                endcase
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: check missed, got sampled at cycle %0d", e.name, e.cyc, cyc);
                end else if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d, want %0d", e.name, cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, e1, s, e2, t, n4, e4, p, q, u;
        reset = 1'b1; subir = 1'b0; bajar = 1'b0; Ssup = 1'b0; Sinf = 1'b0;
        step(3);
        r_last = cyc;
        expect_at(cyc, SEL_A, 0, "reset.motor_a");
        expect_at(cyc, SEL_B, 0, "reset.motor_b");
        expect_at(cyc, SEL_MOV, 0, "reset.moving");
        expect_at(cyc, SEL_FLT, 0, "reset.fault");
        expect_at(cyc, SEL_DUTY, 0, "reset.duty");
        reset = 1'b0;

        // Raise: dead time, then ramp to saturation.
        n = cyc; subir = 1'b1; e1 = n + DEAD_CYCLES + 1;
        for (int m = n + 1; m <= e1 + 40; m++) begin
            if (m <= e1) begin
                expect_at(m, SEL_A, 0, "dead_up.motor_a");
                expect_at(m, SEL_B, 0, "dead_up.motor_b");
                expect_at(m, SEL_MOV, 0, "dead_up.moving");
            end
            if (m >= e1) expect_at(m, SEL_DUTY, exp_duty(m - e1), "run_up.duty");
            if (m > e1) begin
                expect_at(m, SEL_A, leg_at(m, e1), "run_up.motor_a");
                expect_at(m, SEL_B, 0, "run_up.motor_b");
                expect_at(m, SEL_MOV, 1, "run_up.moving");
            end
        end
        wait_until(e1 + 40);

        // Reverse: both legs low through dead time, then RUN_DN restarts duty.
        s = cyc; subir = 1'b0; bajar = 1'b1; e2 = s + DEAD_CYCLES + 1;
        expect_at(s + 1, SEL_MOV, 1, "rev.moving_last");
        for (int m = s + 2; m <= e2 + 20; m++) begin
            if (m <= e2) begin
                expect_at(m, SEL_A, 0, "rev_dead.motor_a");
                expect_at(m, SEL_B, 0, "rev_dead.motor_b");
                expect_at(m, SEL_MOV, 0, "rev_dead.moving");
            end
            if (m >= e2) expect_at(m, SEL_DUTY, exp_duty(m - e2), "run_dn.duty");
            if (m > e2) begin
                expect_at(m, SEL_A, 0, "run_dn.motor_a");
                expect_at(m, SEL_B, leg_at(m, e2), "run_dn.motor_b");
                expect_at(m, SEL_MOV, 1, "run_dn.moving");
            end
        end
        wait_until(e2 + 20);

        // Lower end-stop reached: drive cut, settle to IDLE while bajar held.
        t = cyc; Sinf = 1'b1;
        expect_at(t + 1, SEL_MOV, 1, "sinf.moving_last");
        for (int m = t + 2; m <= t + 12; m++) begin
            expect_at(m, SEL_A, 0, "sinf.motor_a");
            expect_at(m, SEL_B, 0, "sinf.motor_b");
            expect_at(m, SEL_MOV, 0, "sinf.moving");
        end
        wait_until(t + 12);
        bajar = 1'b0; Sinf = 1'b0;
        step(2);

        // Travel timeout: FAULT after 100 run cycles, cleared once both requests drop.
        n4 = cyc; subir = 1'b1; e4 = n4 + DEAD_CYCLES + 1;
        expect_at(e4 + TIMEOUT_CYCLES, SEL_FLT, 0, "tmo.fault_before");
        expect_at(e4 + TIMEOUT_CYCLES, SEL_MOV, 1, "tmo.moving_before");
        expect_at(e4 + TIMEOUT_CYCLES + 1, SEL_FLT, 1, "tmo.fault");
        expect_at(e4 + TIMEOUT_CYCLES + 1, SEL_A, 0, "tmo.motor_a");
        expect_at(e4 + TIMEOUT_CYCLES + 1, SEL_B, 0, "tmo.motor_b");
        expect_at(e4 + TIMEOUT_CYCLES + 1, SEL_MOV, 0, "tmo.moving");
        expect_at(n4 + 120, SEL_FLT, 1, "tmo.fault_held");
        expect_at(n4 + 120, SEL_A, 0, "tmo.motor_a_held");
        wait_until(n4 + 120);
        p = cyc; subir = 1'b0;
        expect_at(p + 1, SEL_FLT, 1, "clr.fault_last");
        expect_at(p + 2, SEL_FLT, 0, "clr.fault");
        expect_at(p + 2, SEL_MOV, 0, "clr.moving");
        wait_until(p + 2);

        // Conflicting requests, then raise against the upper end-stop: no motion.
        q = cyc; subir = 1'b1; bajar = 1'b1;
        for (int m = q + 1; m <= q + 10; m++) begin
            expect_at(m, SEL_MOV, 0, "both.moving");
            expect_at(m, SEL_A, 0, "both.motor_a");
            expect_at(m, SEL_B, 0, "both.motor_b");
        end
        wait_until(q + 10);
        bajar = 1'b0; Ssup = 1'b1;
        for (int m = q + 11; m <= q + 20; m++) begin
            expect_at(m, SEL_MOV, 0, "ssup.moving");
            expect_at(m, SEL_A, 0, "ssup.motor_a");
        end
        wait_until(q + 20);
        subir = 1'b0; Ssup = 1'b0;
        step(2);

        // Reset mid-run kills drive on that edge.
        u = cyc; subir = 1'b1;
        expect_at(u + 20, SEL_MOV, 1, "rst_run.moving_before");
        wait_until(u + 20);
        reset = 1'b1;
        expect_at(u + 21, SEL_A, 0, "rst_run.motor_a");
        expect_at(u + 21, SEL_B, 0, "rst_run.motor_b");
        expect_at(u + 21, SEL_MOV, 0, "rst_run.moving");
        expect_at(u + 21, SEL_FLT, 0, "rst_run.fault");
        expect_at(u + 21, SEL_DUTY, 0, "rst_run.duty");
        step(1);
        reset = 1'b0; subir = 1'b0; r_last = cyc;
        expect_at(u + 24, SEL_MOV, 0, "rst_run.idle_after");
        step(4);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step(1);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/persiana_motor_driver.md
Name: persiana_motor_driver

Overview:
- Downstream stage of the blind-control FSM: consumes its subir/bajar motion requests and drives the H-bridge of the blind motor.
- Enforces dead time between any bridge-leg change and ramps PWM duty for soft start.
- Cuts drive at the end-stop sensors and trips a fault if a run exceeds a travel timeout.
- Sits between the FSM outputs and the board pins; led[1:0] keep mirroring subir/bajar at top level.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty register.
- DEAD_CYCLES, 16, clk cycles both bridge legs are held low before any run starts.
- RAMP_STEP_CYCLES, 256, clk cycles between +1 duty increments.
- TIMEOUT_CYCLES, 2**20, maximum clk cycles in one run before FAULT.

Ports:
- clk  in  1  system clock (same domain as the FSM's Reloj).
- reset  in  1  synchronous, active-high reset.
- subir  in  1  raise request from the FSM.
- bajar  in  1  lower request from the FSM.
- Ssup  in  1  upper end-stop sensor, 1 = blind fully up.
- Sinf  in  1  lower end-stop sensor, 1 = blind fully down.
- motor_a  out  1  bridge leg A (raise), registered.
- motor_b  out  1  bridge leg B (lower), registered.
- moving  out  1  1 while in RUN_UP or RUN_DN.
- fault  out  1  1 while in FAULT.
- duty  out  PWM_BITS  current duty value.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
  - On reset: state IDLE; all counters 0; duty 0; motor_a, motor_b, moving, fault all 0. Takes effect at the next clk edge.
  - Reset asserted mid-run kills drive on that edge, with no dead-time wait.
- Command decode:
  - cmd_up = subir & ~bajar & ~Ssup.
  - cmd_dn = bajar & ~subir & ~Sinf.
  - subir and bajar both high is treated as stop.
- States: IDLE, DEAD, RUN_UP, RUN_DN, FAULT.
- IDLE: outputs 0. cmd_up or cmd_dn moves to DEAD and clears dead_cnt.
- DEAD: outputs 0. dead_cnt increments each cycle. When dead_cnt == DEAD_CYCLES-1:
  - cmd_up goes to RUN_UP; otherwise cmd_dn goes to RUN_DN; otherwise IDLE.
  - On entering RUN_x: duty, ramp_cnt and run_cnt are cleared.
- RUN_UP: motor_a = (pwm_cnt < duty); motor_b = 0.
  - Leaves to DEAD when cmd_up is 0, which covers request drop, bajar asserted, or Ssup reached.
- RUN_DN: motor_b = (pwm_cnt < duty); motor_a = 0.
  - Leaves to DEAD when cmd_dn is 0.
- Reversal: always runs RUN_x → DEAD → RUN_opposite, giving at least DEAD_CYCLES cycles with both legs low.
- Bridge safety: motor_a and motor_b are never 1 in the same cycle, nor in consecutive cycles on opposite legs.
- PWM and ramp:
  - pwm_cnt is free-running, PWM_BITS wide, and wraps.
  - In RUN_x, ramp_cnt counts to RAMP_STEP_CYCLES-1, then wraps and duty increments.
  - duty saturates at 2**PWM_BITS-1, which gives 100%-minus-one-slot drive. Duty is never allowed to wrap.
- Timeout: run_cnt increments in RUN_x. Reaching TIMEOUT_CYCLES-1 moves to FAULT; this takes priority over any sensor or command change in the same cycle.
- FAULT: outputs 0; fault = 1. Stays until subir == 0 and bajar == 0 in the same cycle, then goes to IDLE and fault clears on the next cycle.
- Output latency: motor_a, motor_b, moving and fault are registered, appearing one clk after the state/compare that produces them.

Optional Feature:
- Macro: PERSIANA_SOFT_START_EN.
- Defined: duty ramps as described above.
- Undefined: duty is forced to 2**PWM_BITS-1 on RUN_x entry, so the active leg is 1 except at pwm_cnt == max. The ramp counter is not built.
- Dead time, timeout and FAULT behave identically in both builds.

Decomposition:
- Package persiana_pkg:
  - state encoding constants (IDLE=0, DEAD=1, RUN_UP=2, RUN_DN=3, FAULT=4, 3-bit);
  - default PWM_BITS, DEAD_CYCLES and TIMEOUT_CYCLES constants.
- One sub-module, persiana_pwm_gen: free-running pwm_cnt plus duty compare, producing pwm_on.
- The driver itself owns the FSM, ramp, dead-time and timeout counters.

Test Plan:
Bench parameters: PWM_BITS=4, DEAD_CYCLES=4, RAMP_STEP_CYCLES=2, TIMEOUT_CYCLES=100.
- Reset then subir=1, Ssup=0 → motor_a=motor_b=0 for 4 cycles of DEAD, then moving=1; duty steps 0,1,2… every 2 cycles and saturates at 15; motor_b stays 0.
- While RUN_UP, set bajar=1, subir=0 → motor_a=0 within 1 cycle; both legs 0 for ≥4 cycles; then RUN_DN with duty restarting at 0.
- RUN_DN, raise Sinf=1 → RUN_DN→DEAD→IDLE; motor_b=0 the cycle after the edge; moving=0.
- subir=1 held with Ssup=0 for 120 cycles → FAULT at run cycle 100, fault=1, legs 0; subir=0, bajar=0 → fault=0, IDLE.
- subir=bajar=1 from IDLE → stays IDLE, outputs 0. Assert reset mid-RUN_UP → all outputs 0 on the next edge.
- Build without PERSIANA_SOFT_START_EN → duty=15 on RUN entry; motor_a low only when pwm_cnt==15.
